// File: rtl/axi4_lite_irq_gen_slave_pkg.sv
// Shared constants and types for the AXI4-Lite PL interrupt generator:
// register offsets, CTRL bit positions, channel FSM states and response codes.
package axi4_pl_irq_gen_pkg;

   localparam logic [3:0] ADDR_CTRL = 4'h0;
   localparam logic [3:0] ADDR_IER  = 4'h4;
   localparam logic [3:0] ADDR_ISR  = 4'h8;
   localparam logic [3:0] ADDR_TRIG = 4'hC;

   localparam int CTRL_GIE  = 0;
   localparam int CTRL_MODE = 1;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   // Expands the four byte strobes into a per-bit write mask.
   function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = {8{strb[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/axi4_lite_irq_gen_slave_if.sv
// AXI4-Lite bus bundle between the interconnect/VIP master and the
// interrupt generator register slave.
interface axi4_lite_irq_gen_slave_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi4_lite_irq_gen_slave_pulse_gen.sv
// Turns the masked "active" condition into the IRQ line: a registered level
// in MODE=1, or a fixed-length non-retriggerable pulse in MODE=0.
module axi4_lite_irq_pulse_gen #(
   parameter int C_IRQ_PULSE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic gie,
   input  logic mode,
   input  logic mode_wr,
   output logic irq
);

   localparam int              CNT_W    = $clog2(C_IRQ_PULSE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(C_IRQ_PULSE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             active_q, active_d;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         level_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         active_q <= active_d;
         level_q  <= level_d;
         cnt_q    <= cnt_d;
      end
   end

   // A running pulse blocks new edges; dropping GIE or touching MODE kills it.
   always_comb begin
      active_d = active;
      level_d  = active;
      cnt_d    = cnt_q;
      if (mode_wr || !gie) begin
         cnt_d = '0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_ONE;
      end else if (!mode && active && !active_q) begin
         cnt_d = CNT_LOAD;
      end
   end

   assign irq = mode ? level_q : (cnt_q != '0);

endmodule

// File: rtl/axi4_lite_irq_gen_slave.sv
// AXI4-Lite register slave for the PL interrupt generator: CTRL/IER/ISR/TRIG
// registers, independent write and read channel FSMs, and the IRQ output stage.
module axi4_lite_irq_gen_slave
   import axi4_pl_irq_gen_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int C_NUM_IRQ          = 4,
   parameter int C_IRQ_PULSE_CYCLES = 16
) (
   input  logic                 s00_axi_aclk,
   input  logic                 s00_axi_aresetn,
   axi4_lite_irq_gen_slave_if.slave s00_axi,
   input  logic [C_NUM_IRQ-1:0] irq_src,
   output logic                 irq
);

   w_state_e w_state_q, w_state_d;
   r_state_e r_state_q, r_state_d;
   logic     awready_q, awready_d;
   logic     bvalid_q, bvalid_d;
   logic     arready_q, arready_d;
   logic     rvalid_q, rvalid_d;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic [1:0]           ctrl_q, ctrl_d;
   logic [C_NUM_IRQ-1:0] ier_q, ier_d;
   logic [C_NUM_IRQ-1:0] isr_q, isr_d;
   logic [C_NUM_IRQ-1:0] irq_src_q;

   logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr, rd_addr;
   logic [3:0]                    wr_word, rd_word;
   logic [C_S_AXI_DATA_WIDTH-1:0] wmask, wbits, rd_mux;
   logic [C_NUM_IRQ-1:0]          w1c, trig_set, hw_rise;
   logic                          wr_en, rd_en, mode_wr, active;
   logic                          unused_bits;

   assign wr_addr = s00_axi.awaddr;
   assign rd_addr = s00_axi.araddr;
   assign wr_word = {wr_addr[3:2], 2'b00};
   assign rd_word = {rd_addr[3:2], 2'b00};

   // Ready is registered, so the handshake edge is the one after ready rises.
   assign wr_en = (w_state_q == W_IDLE) && awready_q && s00_axi.awvalid && s00_axi.wvalid;
   assign rd_en = (r_state_q == R_IDLE) && arready_q && s00_axi.arvalid;

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         ctrl_q    <= '0;
         ier_q     <= '0;
         isr_q     <= '0;
         irq_src_q <= '0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         awready_q <= awready_d;
         bvalid_q  <= bvalid_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         ctrl_q    <= ctrl_d;
         ier_q     <= ier_d;
         isr_q     <= isr_d;
         irq_src_q <= irq_src;
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      awready_d = 1'b0;
      bvalid_d  = bvalid_q;
      case (w_state_q)
         W_IDLE: begin
            if (wr_en) begin
               w_state_d = W_RESP;
               bvalid_d  = 1'b1;
            end else if (s00_axi.awvalid && s00_axi.wvalid) begin
               awready_d = 1'b1;
            end
         end
         W_RESP: begin
            if (s00_axi.bready) begin
               w_state_d = W_IDLE;
               bvalid_d  = 1'b0;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      arready_d = 1'b0;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_IDLE: begin
            if (rd_en) begin
               r_state_d = R_DATA;
               rvalid_d  = 1'b1;
               rdata_d   = rd_mux;
            end else if (s00_axi.arvalid) begin
               arready_d = 1'b1;
            end
         end
         R_DATA: begin
            if (s00_axi.rready) begin
               r_state_d = R_IDLE;
               rvalid_d  = 1'b0;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (rd_word)
         ADDR_CTRL: rd_mux[1:0]           = ctrl_q;
         ADDR_IER:  rd_mux[C_NUM_IRQ-1:0] = ier_q;
         ADDR_ISR:  rd_mux[C_NUM_IRQ-1:0] = isr_q;
         default:   rd_mux                = '0;
      endcase
   end

   // Set sources are OR'd in after the clear, so a set wins a same-cycle W1C.
   always_comb begin
      wmask    = strb_to_mask(s00_axi.wstrb);
      wbits    = s00_axi.wdata & wmask;
      ctrl_d   = ctrl_q;
      ier_d    = ier_q;
      w1c      = '0;
      trig_set = '0;
      mode_wr  = 1'b0;
      if (wr_en) begin
         case (wr_word)
            ADDR_CTRL: begin
               ctrl_d  = (ctrl_q & ~wmask[1:0]) | wbits[1:0];
               mode_wr = wmask[CTRL_MODE];
            end
            ADDR_IER:  ier_d    = (ier_q & ~wmask[C_NUM_IRQ-1:0]) | wbits[C_NUM_IRQ-1:0];
            ADDR_ISR:  w1c      = wbits[C_NUM_IRQ-1:0];
            ADDR_TRIG: trig_set = wbits[C_NUM_IRQ-1:0];
            default:   ;
         endcase
      end
      hw_rise = irq_src & ~irq_src_q;
      isr_d   = (isr_q & ~w1c) | trig_set | hw_rise;
   end

   assign active = ctrl_q[CTRL_GIE] && |(isr_q & ier_q);

   axi4_lite_irq_pulse_gen #(
      .C_IRQ_PULSE_CYCLES (C_IRQ_PULSE_CYCLES)
   ) u_pulse_gen (
      .clk     (s00_axi_aclk),
      .rst_n   (s00_axi_aresetn),
      .active  (active),
      .gie     (ctrl_q[CTRL_GIE]),
      .mode    (ctrl_q[CTRL_MODE]),
      .mode_wr (mode_wr),
      .irq     (irq)
   );

   assign s00_axi.awready = awready_q;
   assign s00_axi.wready  = awready_q;
   assign s00_axi.bvalid  = bvalid_q;
   assign s00_axi.bresp   = AXI_RESP_OKAY;
   assign s00_axi.arready = arready_q;
   assign s00_axi.rvalid  = rvalid_q;
   assign s00_axi.rdata   = rdata_q;
   assign s00_axi.rresp   = AXI_RESP_OKAY;

   assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, wr_addr[1:0], rd_addr[1:0], wbits, wmask};

endmodule

// File: tb/tb_axi4_lite_irq_gen_slave.sv
// Directed bench for the AXI4-Lite interrupt generator: a register-access
// vector table followed by hand-written multi-cycle sequences.
module tb_axi4_lite_irq_gen_slave;

   typedef struct {
      logic        is_wr;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] irq_src;
   logic       irq;

   int errors = 0;
   int checks = 0;

   logic [1:0]  last_bresp;
   logic [31:0] rd_val;
   logic [1:0]  rd_resp;
   vec_t        vecs[$];

   axi4_lite_irq_gen_slave_if #(.ADDR_W(4), .DATA_W(32)) bus ();

   axi4_lite_irq_gen_slave #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (4),
      .C_NUM_IRQ          (4),
      .C_IRQ_PULSE_CYCLES (16)
   ) dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (rst_n),
      .s00_axi         (bus.slave),
      .irq_src         (irq_src),
      .irq             (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int hold);
      bit hs_now;
      bit done;
      bit stable;
      bus.awaddr  = addr;
      bus.wdata   = data;
      bus.wstrb   = strb;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         hs_now = bus.awready && bus.wready;
         @(posedge clk); #1;
         done = hs_now;
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      if (!done) begin
         check_output("aw_w_timeout", 32'd0, 32'd1);
         return;
      end
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         if (!bus.bvalid || bus.bresp !== 2'b00) stable = 1'b0;
         @(posedge clk); #1;
      end
      if (hold > 0) check_output("bvalid_held", 32'(stable), 32'd1);
      bus.bready = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (bus.bvalid) begin
            last_bresp = bus.bresp;
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      bus.bready = 1'b0;
      if (!done) check_output("b_timeout", 32'd0, 32'd1);
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
      bit hs_now;
      bit done;
      data = 32'hDEAD_BEEF;
      resp = 2'b11;
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         hs_now = bus.arready;
         @(posedge clk); #1;
         done = hs_now;
      end
      bus.arvalid = 1'b0;
      if (!done) begin
         check_output("ar_timeout", 32'd0, 32'd1);
         return;
      end
      bus.rready = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (bus.rvalid) begin
            data = bus.rdata;
            resp = bus.rresp;
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      bus.rready = 1'b0;
      if (!done) check_output("r_timeout", 32'd0, 32'd1);
   endtask

   task automatic apply_stimulus(input int idx, input vec_t v);
      if (v.is_wr) begin
         last_bresp = 2'b11;
         axi_write(v.addr, v.data, v.strb, 0);
         check_output($sformatf("vec%0d_bresp", idx), 32'(last_bresp), 32'd0);
      end else begin
         axi_read(v.addr, rd_val, rd_resp);
         check_output($sformatf("vec%0d_rdata", idx), rd_val, v.exp_rd);
         check_output($sformatf("vec%0d_rresp", idx), 32'(rd_resp), 32'd0);
      end
      check_output($sformatf("vec%0d_irq", idx), 32'(irq), 32'(v.exp_irq));
   endtask

   function automatic vec_t mk(input logic w, input logic [3:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [31:0] e, input logic q);
      vec_t v;
      v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.exp_rd = e; v.exp_irq = q;
      return v;
   endfunction

   initial begin
      bit       flag;
      int       lat;
      int       high_cnt;
      bit       prev_rdy;
      logic [31:0] held;

      // Register map walk in level mode with IER/strobe/W1C corners.
      vecs.push_back(mk(0, 4'h0, 32'h0,        4'h0, 32'h0, 0));
      vecs.push_back(mk(0, 4'h4, 32'h0,        4'h0, 32'h0, 0));
      vecs.push_back(mk(0, 4'h8, 32'h0,        4'h0, 32'h0, 0));
      vecs.push_back(mk(0, 4'hC, 32'h0,        4'h0, 32'h0, 0));
      vecs.push_back(mk(1, 4'h0, 32'h3,        4'hF, 32'h0, 0));
      vecs.push_back(mk(1, 4'h4, 32'hF,        4'hF, 32'h0, 0));
      vecs.push_back(mk(0, 4'h0, 32'h0,        4'h0, 32'h3, 0));
      vecs.push_back(mk(0, 4'h4, 32'h0,        4'h0, 32'hF, 0));
      vecs.push_back(mk(1, 4'h0, 32'hFFFF_FFFF, 4'hF, 32'h0, 0));
      vecs.push_back(mk(0, 4'h0, 32'h0,        4'h0, 32'h3, 0));
      vecs.push_back(mk(1, 4'hC, 32'h5,        4'hF, 32'h0, 1));
      vecs.push_back(mk(0, 4'h8, 32'h0,        4'h0, 32'h5, 1));
      vecs.push_back(mk(1, 4'h8, 32'h1,        4'hF, 32'h0, 1));
      vecs.push_back(mk(0, 4'h8, 32'h0,        4'h0, 32'h4, 1));
      vecs.push_back(mk(1, 4'h8, 32'h4,        4'hF, 32'h0, 0));
      vecs.push_back(mk(0, 4'h8, 32'h0,        4'h0, 32'h0, 0));
      vecs.push_back(mk(1, 4'h4, 32'h0,        4'h0, 32'h0, 0));
      vecs.push_back(mk(0, 4'h4, 32'h0,        4'h0, 32'hF, 0));
      vecs.push_back(mk(1, 4'h4, 32'hFFFF_FF00, 4'hE, 32'h0, 0));
      vecs.push_back(mk(0, 4'h5, 32'h0,        4'h0, 32'hF, 0));
      vecs.push_back(mk(1, 4'hC, 32'hF,        4'h0, 32'h0, 0));
      vecs.push_back(mk(0, 4'h8, 32'h0,        4'h0, 32'h0, 0));
      vecs.push_back(mk(1, 4'h4, 32'h3,        4'h1, 32'h0, 0));
      vecs.push_back(mk(0, 4'h4, 32'h0,        4'h0, 32'h3, 0));
      vecs.push_back(mk(1, 4'h4, 32'hF,        4'hF, 32'h0, 0));

      rst_n = 1'b0;
      irq_src = '0;
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_ready", {28'd0, bus.awready, bus.wready, bus.arready, 1'b0}, 32'd0);
      check_output("reset_valid", {30'd0, bus.bvalid, bus.rvalid}, 32'd0);
      check_output("reset_rdata", bus.rdata, 32'd0);
      check_output("reset_irq", 32'(irq), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) apply_stimulus(i, vecs[i]);

      // AW three cycles ahead of W: no ready until both, then bvalid two cycles later.
      bus.awaddr = 4'h4; bus.wdata = 32'hF; bus.wstrb = 4'hF; bus.awvalid = 1'b1;
      flag = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.awready || bus.wready) flag = 1'b1;
      end
      check_output("aw_only_no_ready", 32'(flag), 32'd0);
      bus.wvalid = 1'b1;
      lat = 0; prev_rdy = 1'b0; flag = 1'b0;
      for (int i = 0; i < 20 && !flag; i++) begin
         @(posedge clk); #1;
         lat++;
         if (prev_rdy) begin
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
         end
         prev_rdy = bus.awready;
         if (bus.bvalid) flag = 1'b1;
      end
      check_output("write_latency", 32'(lat), 32'd2);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b1;
      @(posedge clk); #1;
      bus.bready = 1'b0;
      check_output("bvalid_cleared", 32'(bus.bvalid), 32'd0);

      // Pulse mode: one edge gives exactly 16 cycles, a mid-pulse edge does not extend it.
      axi_write(4'h0, 32'h1, 4'hF, 0);
      irq_src = 4'h4;
      @(posedge clk); #1;
      irq_src = 4'h0;
      high_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (irq) high_cnt++;
         if (i == 5) irq_src = 4'h1;
         if (i == 6) irq_src = 4'h0;
      end
      check_output("pulse_length", 32'(high_cnt), 32'd16);
      axi_read(4'h8, rd_val, rd_resp);
      check_output("isr_after_pulse", rd_val, 32'h5);
      axi_write(4'h8, 32'hF, 4'hF, 0);

      // HW rise lands on the same edge as a W1C of that bit: set must win.
      bus.awaddr = 4'h8; bus.wdata = 32'h2; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      @(posedge clk); #1;
      check_output("collide_awready", 32'(bus.awready), 32'd1);
      irq_src = 4'h2;
      @(posedge clk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      check_output("collide_bvalid", 32'(bus.bvalid), 32'd1);
      bus.bready = 1'b1;
      @(posedge clk); #1;
      bus.bready = 1'b0;
      axi_read(4'h8, rd_val, rd_resp);
      check_output("collide_isr", rd_val, 32'h2);
      irq_src = 4'h0;
      axi_write(4'h8, 32'h2, 4'hF, 0);

      // Back-pressure on B, then on R while ISR changes underneath the held data.
      axi_write(4'h4, 32'hF, 4'hF, 10);
      bus.araddr = 4'h8; bus.arvalid = 1'b1;
      flag = 1'b0;
      for (int i = 0; i < 20 && !flag; i++) begin
         @(posedge clk); #1;
         if (bus.rvalid) flag = 1'b1;
      end
      bus.arvalid = 1'b0;
      check_output("hold_rvalid_seen", 32'(flag), 32'd1);
      held = bus.rdata;
      check_output("hold_rdata_first", held, 32'h0);
      flag = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 0) irq_src = 4'h8;
         if (i == 1) irq_src = 4'h0;
         @(posedge clk); #1;
         if (!bus.rvalid || bus.rdata !== held) flag = 1'b0;
      end
      check_output("rdata_held", 32'(flag), 32'd1);
      bus.rready = 1'b1;
      @(posedge clk); #1;
      bus.rready = 1'b0;
      check_output("rvalid_cleared", 32'(bus.rvalid), 32'd0);
      axi_read(4'h8, rd_val, rd_resp);
      check_output("isr_after_hold", rd_val, 32'h8);
      axi_write(4'h8, 32'h8, 4'hF, 0);

      // Clearing GIE mid-pulse drops irq on the next cycle.
      axi_write(4'hC, 32'h1, 4'hF, 0);
      check_output("gie_pulse_started", 32'(irq), 32'd1);
      axi_write(4'h0, 32'h0, 4'hF, 0);
      check_output("gie_clear_kills", 32'(irq), 32'd0);

      // Reset asserted while read data is pending.
      bus.araddr = 4'h8; bus.arvalid = 1'b1;
      flag = 1'b0;
      for (int i = 0; i < 20 && !flag; i++) begin
         @(posedge clk); #1;
         if (bus.rvalid) flag = 1'b1;
      end
      check_output("midread_rvalid", 32'(flag), 32'd1);
      rst_n = 1'b0;
      #2;
      bus.arvalid = 1'b0;
      check_output("midread_reset_rvalid", 32'(bus.rvalid), 32'd0);
      check_output("midread_reset_rdata", bus.rdata, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      axi_read(4'h8, rd_val, rd_resp);
      check_output("post_reset_isr", rd_val, 32'h0);
      axi_read(4'h4, rd_val, rd_resp);
      check_output("post_reset_ier", rd_val, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
